// File: rtl/sb_pkg.sv
// Shared constants, FSM encoding and entry-field helpers for the posted-store buffer.
package sb_pkg;

  localparam int SB_DATA_W  = 32;
  localparam int SB_BYTES_W = 4;
  localparam int SB_SIZE_W  = 3;

  typedef enum logic [1:0] {
    SB_IDLE   = 2'd0,
    SB_ACTIVE = 2'd1,
    SB_FLUSH  = 2'd2
  } sb_state_e;

  function automatic logic [SB_SIZE_W-1:0] size_bytes(input logic is_byte);
    return is_byte ? SB_SIZE_W'(1) : SB_SIZE_W'(SB_BYTES_W);
  endfunction

endpackage

// File: rtl/sb_overlap_check.sv
// Compares one buffered store against the current load footprint, with addresses
// wrapping modulo 2^MEM_AW exactly as the data memory does.
module sb_overlap_check
  import sb_pkg::*;
#(
  parameter int MEM_AW = 8
) (
  input  logic              e_valid,
  input  logic              e_sbyte,
  input  logic [MEM_AW-1:0] e_addr,
  input  logic              ld_byte,
  input  logic [MEM_AW-1:0] ld_addr,
  output logic              overlap,
  output logic              full_cover,
  output logic [1:0]        byte_off
);

  logic [MEM_AW-1:0]    fwd_dist;
  logic [MEM_AW-1:0]    back_dist;
  logic [SB_SIZE_W-1:0] e_size;
  logic [SB_SIZE_W-1:0] ld_size;

  assign e_size    = size_bytes(e_sbyte);
  assign ld_size   = size_bytes(ld_byte);
  assign fwd_dist  = ld_addr - e_addr;
  assign back_dist = e_addr - ld_addr;

  // Two byte ranges intersect iff one start lies inside the other range.
  assign overlap    = e_valid && ((fwd_dist < MEM_AW'(e_size)) ||
                                  (back_dist < MEM_AW'(ld_size)));
  assign full_cover = e_valid && (e_size >= ld_size) &&
                      (fwd_dist <= MEM_AW'(e_size - ld_size));
  assign byte_off   = fwd_dist[1:0];

endmodule

// File: rtl/store_buffer.sv
// Posted-store FIFO between MEM stage and data memory; loads have port priority.
// Build option: define SB_FORWARD_EN to forward fully-covered load bytes from pending stores.
module store_buffer
  import sb_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32,
  parameter int MEM_AW = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_SB_stValid,
  input  logic                 i_SB_sByte,
  input  logic [ADDR_W-1:0]    i_SB_addr,
  input  logic [SB_DATA_W-1:0] i_SB_wData,
  output logic                 o_SB_stReady,
  input  logic                 i_SB_ldValid,
  input  logic                 i_SB_ldByte,
  input  logic [ADDR_W-1:0]    i_SB_ldAddr,
  output logic [SB_DATA_W-1:0] o_SB_ldData,
  output logic                 o_SB_ldStall,
  input  logic                 i_SB_flush,
  output logic                 o_SB_flushDone,
  output logic                 o_SB_empty,
  output logic                 o_SB_dMemWe,
  output logic                 o_SB_memSByte,
  output logic [ADDR_W-1:0]    o_SB_memAddr,
  output logic [SB_DATA_W-1:0] o_SB_memWData,
  input  logic [SB_DATA_W-1:0] i_SB_memRData
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [DEPTH-1:0]     e_valid;
  logic                 e_sbyte [DEPTH];
  logic [ADDR_W-1:0]    e_addr  [DEPTH];
  logic [SB_DATA_W-1:0] e_data  [DEPTH];

  logic [PTR_W-1:0]     head, tail, scan_idx, sel_idx;
  logic [PTR_W:0]       count;
  sb_state_e            state, state_nxt;

  logic [DEPTH-1:0]      ov, cov;
  logic [DEPTH-1:0][1:0] offs;
  logic                  hit, ld_block, ld_fire, push, pop;

  for (genvar g = 0; g < DEPTH; g++) begin : g_ovl
    sb_overlap_check #(.MEM_AW(MEM_AW)) u_ovl (
      .e_valid   (e_valid[g]),
      .e_sbyte   (e_sbyte[g]),
      .e_addr    (e_addr[g][MEM_AW-1:0]),
      .ld_byte   (i_SB_ldByte),
      .ld_addr   (i_SB_ldAddr[MEM_AW-1:0]),
      .overlap   (ov[g]),
      .full_cover(cov[g]),
      .byte_off  (offs[g])
    );
  end

  // Scan oldest to youngest so the youngest overlapping entry wins.
  always_comb begin
    hit      = 1'b0;
    sel_idx  = '0;
    scan_idx = '0;
    for (int k = 0; k < DEPTH; k++) begin
      scan_idx = head + PTR_W'(k);
      if (ov[scan_idx]) begin
        hit     = 1'b1;
        sel_idx = scan_idx;
      end
    end
  end

`ifdef SB_FORWARD_EN
  logic [SB_DATA_W-1:0] fwd_word, fwd_data;
  logic [1:0]           sel_off;

  assign fwd_word = e_data[sel_idx];
  assign sel_off  = offs[sel_idx];
  assign ld_block = hit && !cov[sel_idx];

  always_comb begin
    fwd_data = fwd_word;
    if (e_sbyte[sel_idx])
      fwd_data = {24'd0, fwd_word[7:0]};
    else if (i_SB_ldByte)
      fwd_data = {24'd0, fwd_word[{sel_off, 3'b000} +: 8]};
  end

  assign o_SB_ldData = (i_SB_ldValid && hit && cov[sel_idx]) ? fwd_data : i_SB_memRData;
`else
  logic unused_fwd;
  assign unused_fwd  = ^{cov, offs, sel_idx};
  assign ld_block    = hit;
  assign o_SB_ldData = i_SB_memRData;
`endif

  assign o_SB_ldStall = i_SB_ldValid && ld_block;
  assign ld_fire      = i_SB_ldValid && !o_SB_ldStall;
  assign o_SB_stReady = (count < (PTR_W+1)'(DEPTH)) && (state != SB_FLUSH);
  assign push         = i_SB_stValid && o_SB_stReady;
  // A stalled load yields the port, so the blocking entry always drains.
  assign pop          = (count != '0) && !ld_fire;
  assign o_SB_empty   = (count == '0);

  assign o_SB_dMemWe   = pop;
  assign o_SB_memAddr  = ld_fire ? i_SB_ldAddr : e_addr[head];
  assign o_SB_memSByte = ld_fire ? i_SB_ldByte : e_sbyte[head];
  assign o_SB_memWData = e_data[head];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head    <= '0;
      tail    <= '0;
      count   <= '0;
      e_valid <= '0;
      state   <= SB_IDLE;
    end else begin
      state <= state_nxt;
      if (pop) begin
        e_valid[head] <= 1'b0;
        head          <= head + 1'b1;
      end
      if (push) begin
        e_valid[tail] <= 1'b1;
        tail          <= tail + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      e_sbyte[tail] <= i_SB_sByte;
      e_addr[tail]  <= i_SB_addr;
      e_data[tail]  <= i_SB_wData;
    end
  end

  always_comb begin
    state_nxt      = state;
    o_SB_flushDone = 1'b0;
    case (state)
      SB_IDLE: begin
        if (i_SB_flush)  state_nxt = SB_FLUSH;
        else if (push)   state_nxt = SB_ACTIVE;
      end
      SB_ACTIVE: begin
        if (i_SB_flush)  state_nxt = SB_FLUSH;
        else if (pop && !push && count == (PTR_W+1)'(1)) state_nxt = SB_IDLE;
      end
      SB_FLUSH: begin
        if (count == '0) begin
          state_nxt      = SB_IDLE;
          o_SB_flushDone = 1'b1;
        end
      end
      default: state_nxt = SB_IDLE;
    endcase
  end

endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer with a byte-addressed 256-byte memory model.
// Expectations follow SB_FORWARD_EN when the bench is built with that macro.
module tb_store_buffer;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_SB_stValid, i_SB_sByte;
  logic [31:0] i_SB_addr, i_SB_wData;
  logic        o_SB_stReady;
  logic        i_SB_ldValid, i_SB_ldByte;
  logic [31:0] i_SB_ldAddr, o_SB_ldData;
  logic        o_SB_ldStall;
  logic        i_SB_flush, o_SB_flushDone, o_SB_empty;
  logic        o_SB_dMemWe, o_SB_memSByte;
  logic [31:0] o_SB_memAddr, o_SB_memWData, i_SB_memRData;

  logic [7:0] mem [256];
  logic [7:0] a0, a1, a2, a3;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  store_buffer #(.DEPTH(4), .ADDR_W(32), .MEM_AW(8)) dut (
    .clk(clk), .rst(rst),
    .i_SB_stValid(i_SB_stValid), .i_SB_sByte(i_SB_sByte), .i_SB_addr(i_SB_addr),
    .i_SB_wData(i_SB_wData), .o_SB_stReady(o_SB_stReady),
    .i_SB_ldValid(i_SB_ldValid), .i_SB_ldByte(i_SB_ldByte), .i_SB_ldAddr(i_SB_ldAddr),
    .o_SB_ldData(o_SB_ldData), .o_SB_ldStall(o_SB_ldStall),
    .i_SB_flush(i_SB_flush), .o_SB_flushDone(o_SB_flushDone), .o_SB_empty(o_SB_empty),
    .o_SB_dMemWe(o_SB_dMemWe), .o_SB_memSByte(o_SB_memSByte), .o_SB_memAddr(o_SB_memAddr),
    .o_SB_memWData(o_SB_memWData), .i_SB_memRData(i_SB_memRData)
  );

  assign a0 = o_SB_memAddr[7:0];
  assign a1 = a0 + 8'd1;
  assign a2 = a0 + 8'd2;
  assign a3 = a0 + 8'd3;

  always_comb begin
    if (o_SB_memSByte) i_SB_memRData = {24'd0, mem[a0]};
    else               i_SB_memRData = {mem[a3], mem[a2], mem[a1], mem[a0]};
  end

  always @(posedge clk) begin
    if (o_SB_dMemWe) begin
      mem[a0] <= o_SB_memWData[7:0];
      if (!o_SB_memSByte) begin
        mem[a1] <= o_SB_memWData[15:8];
        mem[a2] <= o_SB_memWData[23:16];
        mem[a3] <= o_SB_memWData[31:24];
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic store(input logic sb, input logic [31:0] ad, input logic [31:0] d);
    i_SB_stValid = 1'b1;
    i_SB_sByte   = sb;
    i_SB_addr    = ad;
    i_SB_wData   = d;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    rst = 1'b1;
    i_SB_stValid = 1'b0; i_SB_sByte = 1'b0; i_SB_addr = '0; i_SB_wData = '0;
    i_SB_ldValid = 1'b0; i_SB_ldByte = 1'b0; i_SB_ldAddr = '0; i_SB_flush = 1'b0;
    tick(); tick();
    check("rst_stReady", o_SB_stReady, 1);
    check("rst_empty", o_SB_empty, 1);
    check("rst_dMemWe", o_SB_dMemWe, 0);
    check("rst_ldStall", o_SB_ldStall, 0);
    check("rst_flushDone", o_SB_flushDone, 0);
    rst = 1'b0;
    tick();

    // 1: single word store drains the following cycle
    store(1'b0, 32'h10, 32'h11223344);
    #1;
    check("t1_ready", o_SB_stReady, 1);
    check("t1_no_we_at_push", o_SB_dMemWe, 0);
    tick();
    i_SB_stValid = 1'b0;
    #1;
    check("t1_we", o_SB_dMemWe, 1);
    check("t1_addr", o_SB_memAddr, 32'h10);
    check("t1_wdata", o_SB_memWData, 32'h11223344);
    check("t1_sbyte", o_SB_memSByte, 0);
    tick();
    check("t1_empty", o_SB_empty, 1);
    check("t1_we_off", o_SB_dMemWe, 0);
    i_SB_ldValid = 1'b1; i_SB_ldByte = 1'b0; i_SB_ldAddr = 32'h10;
    #1;
    check("t1_rd_word", o_SB_ldData, 32'h11223344);
    check("t1_rd_stall", o_SB_ldStall, 0);
    i_SB_ldByte = 1'b1; i_SB_ldAddr = 32'h12;
    #1;
    check("t1_rd_byte", o_SB_ldData, 32'h00000022);

    // 2: fill while a non-overlapping load holds the port, then drain in order
    i_SB_ldByte = 1'b0; i_SB_ldAddr = 32'h80;
    for (int i = 0; i < 4; i++) begin
      store(1'b0, 32'h40 + 32'(4 * i), 32'h10000000 + 32'(i));
      #1;
      check("t2_fill_ready", o_SB_stReady, 1);
      check("t2_fill_no_we", o_SB_dMemWe, 0);
      tick();
    end
    store(1'b0, 32'h60, 32'hDEADBEEF);
    #1;
    check("t2_full_ready", o_SB_stReady, 0);
    check("t2_full_no_we", o_SB_dMemWe, 0);
    check("t2_full_nonempty", o_SB_empty, 0);
    tick();
    i_SB_stValid = 1'b0; i_SB_ldValid = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) begin
      check("t2_drain_we", o_SB_dMemWe, 1);
      check("t2_drain_addr", o_SB_memAddr, 32'h40 + 32'(4 * i));
      check("t2_drain_data", o_SB_memWData, 32'h10000000 + 32'(i));
      tick();
    end
    check("t2_empty", o_SB_empty, 1);
    check("t2_idle_we", o_SB_dMemWe, 0);
    i_SB_ldValid = 1'b1; i_SB_ldAddr = 32'h4C;
    #1;
    check("t2_rd_last", o_SB_ldData, 32'h10000003);
    i_SB_ldAddr = 32'h60;
    #1;
    check("t2_rejected_store", o_SB_ldData, 32'h0);
    i_SB_ldValid = 1'b0;

    // 3: byte load inside a pending word store
    store(1'b0, 32'h20, 32'hAABBCCDD);
    tick();
    i_SB_stValid = 1'b0;
    i_SB_ldValid = 1'b1; i_SB_ldByte = 1'b1; i_SB_ldAddr = 32'h22;
    #1;
`ifdef SB_FORWARD_EN
    check("t3_fwd_stall", o_SB_ldStall, 0);
    check("t3_fwd_data", o_SB_ldData, 32'h000000BB);
    check("t3_fwd_no_we", o_SB_dMemWe, 0);
    i_SB_ldValid = 1'b0;
    #1;
    check("t3_drain_addr", o_SB_memAddr, 32'h20);
    tick();
`else
    check("t3_stall", o_SB_ldStall, 1);
    check("t3_drain_we", o_SB_dMemWe, 1);
    check("t3_drain_addr", o_SB_memAddr, 32'h20);
    tick();
    check("t3_release", o_SB_ldStall, 0);
    check("t3_mem_data", o_SB_ldData, 32'h000000BB);
    i_SB_ldValid = 1'b0;
`endif
    #1;
    check("t3_empty", o_SB_empty, 1);

    // 4: word load partially covered by a byte store
    store(1'b1, 32'h30, 32'h1234565A);
    tick();
    i_SB_stValid = 1'b0;
    i_SB_ldValid = 1'b1; i_SB_ldByte = 1'b0; i_SB_ldAddr = 32'h30;
    #1;
    check("t4_stall", o_SB_ldStall, 1);
    check("t4_drain_we", o_SB_dMemWe, 1);
    check("t4_drain_addr", o_SB_memAddr, 32'h30);
    check("t4_drain_sbyte", o_SB_memSByte, 1);
    tick();
    check("t4_release", o_SB_ldStall, 0);
    check("t4_no_we", o_SB_dMemWe, 0);
    check("t4_mem_data", o_SB_ldData, 32'h0000005A);
    i_SB_ldValid = 1'b0;

    // 5: word store wrapping past 0xFF
    store(1'b0, 32'hFE, 32'h01020304);
    tick();
    i_SB_stValid = 1'b0;
    i_SB_ldValid = 1'b1; i_SB_ldByte = 1'b1; i_SB_ldAddr = 32'h02;
    #1;
    check("t5_beyond_stall", o_SB_ldStall, 0);
    check("t5_beyond_data", o_SB_ldData, 32'h0);
    check("t5_beyond_no_we", o_SB_dMemWe, 0);
    i_SB_ldAddr = 32'h01;
    #1;
`ifdef SB_FORWARD_EN
    check("t5_wrap_stall", o_SB_ldStall, 0);
    check("t5_wrap_fwd", o_SB_ldData, 32'h00000001);
    i_SB_ldValid = 1'b0;
    tick();
`else
    check("t5_wrap_stall", o_SB_ldStall, 1);
    check("t5_wrap_drain", o_SB_memAddr, 32'hFE);
    tick();
    check("t5_wrap_release", o_SB_ldStall, 0);
    check("t5_wrap_mem", o_SB_ldData, 32'h00000001);
`endif
    check("t5_empty", o_SB_empty, 1);
    i_SB_ldValid = 1'b1; i_SB_ldByte = 1'b0; i_SB_ldAddr = 32'hFE;
    #1;
    check("t5_wrap_word", o_SB_ldData, 32'h01020304);
    i_SB_ldValid = 1'b0;

    // 6: flush with three pending entries
    i_SB_ldValid = 1'b1; i_SB_ldByte = 1'b0; i_SB_ldAddr = 32'h80;
    for (int i = 0; i < 3; i++) begin
      store(1'b0, 32'h90 + 32'(4 * i), 32'h20000000 + 32'(i));
      tick();
    end
    i_SB_stValid = 1'b0; i_SB_ldValid = 1'b0; i_SB_flush = 1'b1;
    #1;
    check("t6_d0_addr", o_SB_memAddr, 32'h90);
    check("t6_d0_done", o_SB_flushDone, 0);
    tick();
    i_SB_flush = 1'b0;
    #1;
    check("t6_flush_ready", o_SB_stReady, 0);
    check("t6_d1_addr", o_SB_memAddr, 32'h94);
    check("t6_d1_done", o_SB_flushDone, 0);
    tick();
    check("t6_d2_addr", o_SB_memAddr, 32'h98);
    check("t6_d2_done", o_SB_flushDone, 0);
    tick();
    check("t6_done", o_SB_flushDone, 1);
    check("t6_done_empty", o_SB_empty, 1);
    check("t6_done_no_we", o_SB_dMemWe, 0);
    check("t6_done_ready", o_SB_stReady, 0);
    tick();
    check("t6_done_pulse", o_SB_flushDone, 0);
    check("t6_ready_back", o_SB_stReady, 1);

    i_SB_flush = 1'b1;
    #1;
    check("t6_empty_flush_now", o_SB_flushDone, 0);
    tick();
    i_SB_flush = 1'b0;
    #1;
    check("t6_empty_flush_done", o_SB_flushDone, 1);
    tick();
    check("t6_empty_flush_pulse", o_SB_flushDone, 0);

    // reset in the middle of a flush discards what is left
    i_SB_ldValid = 1'b1; i_SB_ldAddr = 32'h80;
    for (int i = 0; i < 3; i++) begin
      store(1'b0, 32'hA0 + 32'(4 * i), 32'h30000000 + 32'(i));
      tick();
    end
    i_SB_stValid = 1'b0; i_SB_ldValid = 1'b0; i_SB_flush = 1'b1;
    tick();
    i_SB_flush = 1'b0;
    #1;
    check("t6_mid_we", o_SB_dMemWe, 1);
    check("t6_mid_addr", o_SB_memAddr, 32'hA4);
    rst = 1'b1;
    #1;
    check("t6_rst_empty", o_SB_empty, 1);
    check("t6_rst_we", o_SB_dMemWe, 0);
    check("t6_rst_ready", o_SB_stReady, 1);
    check("t6_rst_done", o_SB_flushDone, 0);
    tick();
    rst = 1'b0;
    tick();
    i_SB_ldValid = 1'b1; i_SB_ldAddr = 32'hA4;
    #1;
    check("t6_discarded", o_SB_ldData, 32'h0);
    i_SB_ldAddr = 32'hA0;
    #1;
    check("t6_kept", o_SB_ldData, 32'h30000000);
    i_SB_ldValid = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
